// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch to instruction
// memory and buffers returned words in a 2-entry queue whose head feeds the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic StFetch = 1'b0;
  localparam logic StDrain = 1'b1;

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] q_pc_q [2];
  logic [31:0] q_pc_d [2];
  logic [31:0] q_inst_q [2];
  logic [31:0] q_inst_d [2];

  logic        push, pop, wr_idx;
  logic [31:0] target_aligned;
  logic        unused_target_lsbs;

  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
    if (!rst) begin
      imem_req = (state_q == StDrain) ? 1'b1 : (count_q != 2'd2);
    end
  end

  assign if_valid = (count_q != 2'd0);
  assign if_pc    = if_valid ? q_pc_q[0] : 32'h0;
  assign if_inst  = if_valid ? q_inst_q[0] : 32'h0;

  assign push = (state_q == StFetch) && imem_req && imem_ack && !branch;
  assign pop  = if_valid && !stall && !branch;
  // Push never coincides with a full queue, so with a pop the free slot is always entry 0.
  assign wr_idx = pop ? 1'b0 : count_q[0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_q;
    q_pc_d       = q_pc_q;
    q_inst_d     = q_inst_q;
    if (branch) begin
      count_d = 2'd0;
      pc_d    = target_aligned;
      if (state_q == StFetch) begin
        // An unanswered request must still be drained so its late ack is not mistaken for ours.
        if (imem_req && !imem_ack) begin
          state_d      = StDrain;
          drain_addr_d = imem_addr;
        end
      end else if (imem_ack) begin
        state_d = StFetch;
      end
    end else begin
      if ((state_q == StDrain) && imem_ack) begin
        state_d = StFetch;
      end
      if (pop) begin
        q_pc_d[0]   = q_pc_q[1];
        q_inst_d[0] = q_inst_q[1];
      end
      if (push) begin
        pc_d             = pc_q + PC_STEP;
        q_pc_d[wr_idx]   = pc_q;
        q_inst_d[wr_idx] = imem_rdata;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      count_q      <= 2'd0;
      q_pc_q[0]    <= 32'h0;
      q_pc_q[1]    <= 32'h0;
      q_inst_q[0]  <= 32'h0;
      q_inst_q[1]  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      q_pc_q       <= q_pc_d;
      q_inst_q     <= q_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances (reset PC 0 and FFFF_FFF8), each with a memory
// model returning word = address after a programmable number of wait cycles.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, branch;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;
  logic        if_valid;

  logic        rst2, stall2, branch2;
  logic [31:0] target2;
  logic        req2, ack2;
  logic [31:0] addr2, rdata2, pc2, inst2;
  logic        valid2;

  int lat = 0, wcnt = 0, lat2 = 0, wcnt2 = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .branch(branch2), .branch_target(target2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .if_pc(pc2), .if_inst(inst2), .if_valid(valid2)
  );

  // Memory models: ack after 'lat' wait cycles of a held request, data = address.
  assign imem_ack   = imem_req && (wcnt == lat);
  assign imem_rdata = imem_addr;
  assign ack2       = req2 && (wcnt2 == lat2);
  assign rdata2     = addr2;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (rst2 || !req2 || ack2) wcnt2 <= 0;
    else wcnt2 <= wcnt2 + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    tick();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    tests++; if (if_inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", if_inst); end
    rst = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_seq;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_inst !== 32'(4 * i)) begin
        fails++; $display("FAIL seq[%0d]: got v=%b pc=%h inst=%h want pc=inst=%h", i, if_valid, if_pc,
                          if_inst, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall;
    lat = 0;
    do_reset();
    repeat (3) tick();
    tests++; if (if_pc !== 32'h8) begin fails++; $display("FAIL stall_pre: got %h want 8", if_pc); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (if_pc !== 32'h8 || if_inst !== 32'h8 || if_valid !== 1'b1 || imem_req !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d]: got pc=%h inst=%h v=%b req=%b want pc=8 v=1 req=0",
                          i, if_pc, if_inst, if_valid, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (if_pc !== 32'(12 + 4 * i) || if_valid !== 1'b1) begin
        fails++; $display("FAIL stall_release[%0d]: got pc=%h v=%b want %h", i, if_pc, if_valid,
                          32'(12 + 4 * i));
      end
    end
  endtask

  task automatic test_latency;
    logic [31:0] exp_addr, exp_pc;
    lat = 2;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      exp_addr = 32'(4 * (c / 3));
      tests++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        fails++; $display("FAIL lat_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", c, imem_req,
                          imem_addr, exp_addr);
      end
      if (c > 0 && c % 3 == 0) begin
        exp_pc = 32'(4 * (c / 3 - 1));
        tests++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== exp_pc) begin
          fails++; $display("FAIL lat_data[%0d]: got v=%b pc=%h inst=%h want %h", c, if_valid, if_pc,
                            if_inst, exp_pc);
        end
      end else begin
        tests++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
          fails++; $display("FAIL lat_bubble[%0d]: got v=%b pc=%h inst=%h want all 0", c, if_valid,
                            if_pc, if_inst);
        end
      end
    end
  endtask

  task automatic test_branch_drain;
    lat = 0;
    do_reset();
    branch = 1'b1; branch_target = 32'h20;
    tick();
    branch = 1'b0; lat = 2;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin
      fails++; $display("FAIL br_ack_discard: got req=%b addr=%h v=%b want 1/20/0", imem_req,
                        imem_addr, if_valid);
    end
    branch = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin
      fails++; $display("FAIL drain_hold: got req=%b addr=%h v=%b want 1/20/0", imem_req, imem_addr,
                        if_valid);
    end
    tick();
    tests++; if (imem_ack !== 1'b1 || imem_addr !== 32'h20) begin
      fails++; $display("FAIL drain_ack: got ack=%b addr=%h want 1/20", imem_ack, imem_addr);
    end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      fails++; $display("FAIL drain_exit: got req=%b addr=%h v=%b want 1/100/0", imem_req,
                        imem_addr, if_valid);
    end
    lat = 0;
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h100) begin
      fails++; $display("FAIL drain_target: got v=%b pc=%h inst=%h want 100", if_valid, if_pc, if_inst);
    end
    tick();
    tests++; if (if_pc !== 32'h104 || if_inst !== 32'h104) begin
      fails++; $display("FAIL drain_next: got pc=%h inst=%h want 104", if_pc, if_inst);
    end
  endtask

  task automatic test_branch_stall;
    lat = 0;
    do_reset();
    stall = 1'b1;
    repeat (2) tick();
    tests++; if (imem_req !== 1'b0 || if_pc !== 32'h0 || if_valid !== 1'b1) begin
      fails++; $display("FAIL full_stall: got req=%b pc=%h v=%b want 0/0/1", imem_req, if_pc, if_valid);
    end
    branch = 1'b1; branch_target = 32'h40;
    tick();
    branch = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      fails++; $display("FAIL flush_full: got v=%b req=%b addr=%h want 0/1/40", if_valid, imem_req,
                        imem_addr);
    end
    tick();
    tests++; if (if_pc !== 32'h40 || imem_addr !== 32'h44 || imem_ack !== 1'b1) begin
      fails++; $display("FAIL refill: got pc=%h addr=%h ack=%b want 40/44/1", if_pc, imem_addr, imem_ack);
    end
    branch = 1'b1; branch_target = 32'h80;
    tick();
    branch = 1'b0; stall = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b0 || imem_addr !== 32'h80) begin
      fails++; $display("FAIL br_ack_stall: got v=%b addr=%h want 0/80", if_valid, imem_addr);
    end
    tick();
    tests++; if (if_pc !== 32'h80 || if_valid !== 1'b1) begin
      fails++; $display("FAIL br_target: got pc=%h v=%b want 80/1", if_pc, if_valid);
    end
    tick();
    tests++; if (if_pc !== 32'h84) begin fails++; $display("FAIL br_no_stale: got %h want 84", if_pc); end
  endtask

  task automatic test_wrap_drain_reset;
    logic [31:0] exp_pc;
    lat2 = 0;
    tick();
    tests++; if (req2 !== 1'b0 || valid2 !== 1'b0) begin
      fails++; $display("FAIL wrap_rst: got req=%b v=%b want 0/0", req2, valid2);
    end
    rst2 = 1'b0;
    #1;
    tests++; if (addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_addr: got %h want fffffff8", addr2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      tests++; if (valid2 !== 1'b1 || pc2 !== exp_pc || inst2 !== exp_pc) begin
        fails++; $display("FAIL wrap_seq[%0d]: got pc=%h inst=%h want %h", i, pc2, inst2, exp_pc);
      end
    end
    lat2 = 2; branch2 = 1'b1; target2 = 32'h200;
    tick();
    branch2 = 1'b0;
    #1;
    tests++; if (req2 !== 1'b1 || addr2 !== 32'h4 || valid2 !== 1'b0) begin
      fails++; $display("FAIL wrap_drain: got req=%b addr=%h v=%b want 1/4/0", req2, addr2, valid2);
    end
    rst2 = 1'b1;
    tick();
    tests++; if (req2 !== 1'b0 || valid2 !== 1'b0 || pc2 !== 32'h0) begin
      fails++; $display("FAIL drain_rst: got req=%b v=%b pc=%h want 0/0/0", req2, valid2, pc2);
    end
    lat2 = 0; rst2 = 1'b0;
    #1;
    tests++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL drain_rst_fetch: got req=%b addr=%h want 1/fffffff8", req2, addr2);
    end
    tick();
    tests++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL drain_rst_data: got v=%b pc=%h want 1/fffffff8", valid2, pc2);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; branch_target = 32'h0;
    rst2 = 1'b1; stall2 = 1'b0; branch2 = 1'b0; target2 = 32'h0;
    test_reset();
    test_seq();
    test_stall();
    test_latency();
    test_branch_drain();
    test_branch_stall();
    test_wrap_drain_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
